// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the slide-switch conditioner (package sw_pkg).
package sw_pkg;
   localparam int unsigned SW_WIDTH                = 16;
   localparam int unsigned CLK_HZ                  = 100000000;
   localparam int unsigned DEBOUNCE_MS_DEFAULT     = 10;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS_DEFAULT;

   // Stability counter only ever has to reach DEBOUNCE_CYCLES-1.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction
endpackage

// File: rtl/sw_debounce_if.sv
// Switch-conditioner bus: raw pins in, clean level and event pulses out.
// Sticky bank signals exist only when SW_DEBOUNCE_STICKY_EN is defined.
interface sw_debounce_if #(
   parameter int WIDTH = sw_pkg::SW_WIDTH
);
   logic [WIDTH-1:0] sw;
   logic [WIDTH-1:0] sw_clean;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic             sw_changed;
`ifdef SW_DEBOUNCE_STICKY_EN
   logic             sticky_clr;
   logic [WIDTH-1:0] sw_sticky;

   modport slave  (input  sw, sticky_clr,
                   output sw_clean, sw_rise, sw_fall, sw_changed, sw_sticky);
   modport master (output sw, sticky_clr,
                   input  sw_clean, sw_rise, sw_fall, sw_changed, sw_sticky);
`else
   modport slave  (input  sw,
                   output sw_clean, sw_rise, sw_fall, sw_changed);
   modport master (output sw,
                   input  sw_clean, sw_rise, sw_fall, sw_changed);
`endif
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter, clean level and edge pulses.
module sw_debounce_bit
   import sw_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_sw,
   output logic o_clean,
   output logic o_rise,
   output logic o_fall,
   output logic o_rise_next,
   output logic o_fall_next
);
   localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_clean;
   logic                   r_rise;
   logic                   r_fall;

   logic w_sync;
   logic w_mismatch;
   logic w_expire;

   always_comb begin
      w_sync     = r_sync[SYNC_STAGES-1];
      w_mismatch = w_sync ^ r_clean;
      w_expire   = w_mismatch && (r_cnt == CNT_MAX);
   end

   // Counter clears on any agreeing cycle, so it can never run past CNT_MAX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_clean <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
         r_rise <= w_expire &  w_sync;
         r_fall <= w_expire & ~w_sync;
         if (!w_mismatch || w_expire) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_expire) begin
            r_clean <= w_sync;
         end
      end
   end

   assign o_clean     = r_clean;
   assign o_rise      = r_rise;
   assign o_fall      = r_fall;
   assign o_rise_next = w_expire &  w_sync;
   assign o_fall_next = w_expire & ~w_sync;
endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: WIDTH independent debounced bits plus a combined change flag.
// Optional sticky rise bank enabled by defining SW_DEBOUNCE_STICKY_EN.
module sw_debounce
   import sw_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   sw_debounce_if.slave  bus
);
   logic [WIDTH-1:0] w_clean;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_rise_next;
   logic [WIDTH-1:0] w_fall_next;
   logic             r_changed;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      sw_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_sw        (bus.sw[gi]),
         .o_clean     (w_clean[gi]),
         .o_rise      (w_rise[gi]),
         .o_fall      (w_fall[gi]),
         .o_rise_next (w_rise_next[gi]),
         .o_fall_next (w_fall_next[gi])
      );
   end

   // Built from the pre-register pulse terms so it lands in the same cycle as the pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |(w_rise_next | w_fall_next);
      end
   end

   assign bus.sw_clean   = w_clean;
   assign bus.sw_rise    = w_rise;
   assign bus.sw_fall    = w_fall;
   assign bus.sw_changed = r_changed;

`ifdef SW_DEBOUNCE_STICKY_EN
   logic [WIDTH-1:0] r_sticky;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= '0;
      end else begin
         r_sticky <= (r_sticky & ~{WIDTH{bus.sticky_clr}}) | w_rise;
      end
   end

   assign bus.sw_sticky = r_sticky;
`endif
endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
Reader-side conditioner for the 16 board slide switches. It sits between the raw switch pins and any logic that consumes switch state.
- Each bit is synchronised into clk, then debounced with a per-bit stability counter.
- Outputs: a clean level per bit, plus one-cycle rise/fall event pulses.
- Downstream blocks (LED drivers, mode selects) use sw_clean/sw_rise instead of raw pins.

Parameters:
WIDTH, 16, number of switch bits conditioned
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (legal range 2..4)
DEBOUNCE_CYCLES, 1000000, consecutive mismatching clk cycles before the clean level updates (10 ms at 100 MHz); legal range ≥2

Ports:
clk  input  1  system clock, 100 MHz on board
rst_n  input  1  asynchronous active-low reset
sw  input  WIDTH  raw switch pins, asynchronous to clk
sw_clean  output  WIDTH  debounced switch level
sw_rise  output  WIDTH  one-cycle pulse when a bit of sw_clean goes 0->1
sw_fall  output  WIDTH  one-cycle pulse when a bit of sw_clean goes 1->0
sw_changed  output  1  registered OR of (sw_rise | sw_fall), same cycle as the pulses

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, all of the following are 0:
  - synchroniser flops, counters, sw_clean, sw_rise, sw_fall, sw_changed.
  - Deassertion is synchronised externally; the block needs no reset release logic.
- Synchroniser:
  - sw[i] passes through SYNC_STAGES flops.
  - sync[i] is the last stage.
  - No logic sits between stages.
- Per-bit debounce, evaluated every rising edge:
  - sync == clean: counter <= 0.
  - sync != clean and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != clean and counter == DEBOUNCE_CYCLES-1: clean <= sync, counter <= 0, and the matching rise or fall bit is 1 for exactly that one cycle.
- Counter width is clog2(DEBOUNCE_CYCLES), unsigned. The counter saturates by construction and never wraps.
- Latency:
  - Raw level first sampled at edge e0 and held stable: sw_clean updates at edge e0+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - The pulse is high in the cycle following that edge.
- Glitch rejection:
  - Any cycle with sync == clean restarts the count.
  - A bounce shorter than DEBOUNCE_CYCLES consecutive cycles produces no change and no pulse.
- Bits are fully independent. Simultaneous changes on several bits give simultaneous pulses; sw_changed is a single cycle.
- rise and fall for the same bit are never high together.
- Reset mid-count: the counter is discarded; after release, counting restarts from 0 against clean=0.
- A switch held at 1 through reset produces sw_rise once, at the normal latency after release.

Optional Feature:
- Macro SW_DEBOUNCE_STICKY_EN.
- Defined:
  - Adds input sticky_clr (1 bit) and output sw_sticky (WIDTH).
  - sw_sticky[i] sets on sw_rise[i] and clears when sticky_clr=1.
  - Same-cycle set and clear: set wins.
  - Reset value is 0.
- Undefined:
  - Neither port exists and no sticky flops are built.
  - All other behaviour is identical.

Decomposition:
- Shared package/header sw_pkg holds:
  - SW_WIDTH=16, CLK_HZ=100000000, DEBOUNCE_MS_DEFAULT=10.
  - A constant function computing counter width from DEBOUNCE_CYCLES.
- One natural sub-module, sw_debounce_bit:
  - Contains the synchroniser, counter, clean flop and pulse flops for a single bit.
  - Instantiated WIDTH times via generate.
- The top level ORs the pulses into sw_changed and holds the optional sticky bank.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
1. Clean step: sw 0x0000->0x0001 before edge 0, held -> sw_clean=0x0001 after edge 5; sw_rise=0x0001 for one cycle; sw_changed=1 for one cycle; all else 0.
2. Bounce rejection: sw[3] toggles 1,0,1,0 on successive cycles, each high ≤3 cycles -> sw_clean stays 0x0000; no pulses.
3. Multi-bit and fall:
   - sw 0x0000->0xFFFF held -> sw_clean=0xFFFF with sw_rise=0xFFFF in one cycle.
   - Then sw->0x00F0 -> sw_fall=0xFF0F in one cycle, sw_clean=0x00F0.
4. Reset mid-count: sw=0x8000 held; rst_n=0 for 1 cycle after 2 edges of mismatch -> all outputs 0; sw_clean=0x8000 reached at the full latency after release.
5. Sticky (SW_DEBOUNCE_STICKY_EN): rise on bit 2 -> sw_sticky=0x0004 held; sticky_clr=1 in the same cycle as a new rise on bit 2 -> sw_sticky stays 0x0004; sticky_clr alone -> 0x0000.
